// File: rtl/tron_round_if.sv
// Game-state bus between the round sequencer and the arena/display/overlay logic.
// Build macro TRON_PAUSE_EN adds the pause level input.
interface tron_round_if;
  logic       frame_clk;
  logic       start;
  logic       blue_crash;
  logic       red_crash;
`ifdef TRON_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] Game_State;
  logic       reset_round;
  logic [1:0] countdown;
  logic [1:0] score_blue;
  logic [1:0] score_red;
  logic       Blue_W;
  logic       Red_W;

  modport master (
    input  frame_clk, start, blue_crash, red_crash,
`ifdef TRON_PAUSE_EN
    input  pause,
`endif
    output Game_State, reset_round, countdown, score_blue, score_red, Blue_W, Red_W
  );

  modport slave (
    output frame_clk, start, blue_crash, red_crash,
`ifdef TRON_PAUSE_EN
    output pause,
`endif
    input  Game_State, reset_round, countdown, score_blue, score_red, Blue_W, Red_W
  );
endinterface

// File: rtl/tron_round_ctrl.sv
// Light-cycle match/round sequencer: title, countdown, play, round end, match end.
// Build macro TRON_PAUSE_EN adds a pause input that freezes COUNTDOWN and PLAY.
module tron_round_ctrl #(
  parameter int unsigned WIN_SCORE    = 3,
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 90
) (
  input  logic         Clk,
  input  logic         Reset_N,
  tron_round_if.master bus
);
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CD_W    = 2;
  localparam int unsigned SCORE_W = 2;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned SYNC_W  = 3;

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CD_W-1:0]    CD_FIRST   = CD_W'(3);

  typedef enum logic [STATE_W-1:0] {
    S_TITLE     = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_ROUND_END = 3'd3,
    S_MATCH_END = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CD_W-1:0]     cd_q, cd_d;
  logic [SCORE_W-1:0]  sb_q, sb_d, sr_q, sr_d;
  logic                bw_q, bw_d, rw_q, rw_d, rr_q, rr_d;
  logic [SYNC_W-1:0]   frame_sync_q, frame_sync_d, start_sync_q, start_sync_d;
  logic                frame_tick, start_rise, paused, tick_m, blue_m, red_m;

  // [0],[1] synchronize the async level, [2] holds the previous synchronized value
  assign frame_sync_d = {frame_sync_q[1:0], bus.frame_clk};
  assign start_sync_d = {start_sync_q[1:0], bus.start};
  assign frame_tick   = frame_sync_q[1] & ~frame_sync_q[2];
  assign start_rise   = start_sync_q[1] & ~start_sync_q[2];

`ifdef TRON_PAUSE_EN
  assign paused = bus.pause && (state_q == S_COUNTDOWN || state_q == S_PLAY);
`else
  assign paused = 1'b0;
`endif

  assign tick_m = frame_tick & ~paused;
  assign blue_m = bus.blue_crash & ~paused;
  assign red_m  = bus.red_crash & ~paused;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cd_d    = cd_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    bw_d    = bw_q;
    rw_d    = rw_q;
    rr_d    = 1'b0;
    case (state_q)
      S_TITLE: begin
        sb_d = '0;
        sr_d = '0;
        bw_d = 1'b0;
        rw_d = 1'b0;
        cd_d = '0;
        if (start_rise) begin
          state_d = S_COUNTDOWN;
          rr_d    = 1'b1;
          cd_d    = CD_FIRST;
        end
      end
      S_COUNTDOWN: begin
        if (tick_m) begin
          if (cnt_q == COUNT_LAST) begin
            cnt_d = '0;
            if (cd_q == CD_W'(1)) begin
              state_d = S_PLAY;
              cd_d    = '0;
            end else begin
              cd_d = cd_q - CD_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        // only the first crash cycle counts; a simultaneous double crash is a draw
        if (blue_m || red_m) begin
          state_d = S_ROUND_END;
          if (blue_m && !red_m && sr_q < WIN) sr_d = sr_q + SCORE_W'(1);
          if (red_m && !blue_m && sb_q < WIN) sb_d = sb_q + SCORE_W'(1);
        end
      end
      S_ROUND_END: begin
        if (tick_m) begin
          if (cnt_q == HOLD_LAST) begin
            if (sb_q == WIN || sr_q == WIN) begin
              state_d = S_MATCH_END;
              bw_d    = (sb_q == WIN);
              rw_d    = (sr_q == WIN) && (sb_q != WIN);
            end else begin
              state_d = S_COUNTDOWN;
              rr_d    = 1'b1;
              cd_d    = CD_FIRST;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_MATCH_END: begin
        bw_d = (sb_q == WIN);
        rw_d = (sr_q == WIN) && (sb_q != WIN);
        if (start_rise) begin
          state_d = S_TITLE;
          sb_d    = '0;
          sr_d    = '0;
          bw_d    = 1'b0;
          rw_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_TITLE;
        cd_d    = '0;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state_q      <= S_TITLE;
      cnt_q        <= '0;
      cd_q         <= '0;
      sb_q         <= '0;
      sr_q         <= '0;
      bw_q         <= 1'b0;
      rw_q         <= 1'b0;
      rr_q         <= 1'b0;
      frame_sync_q <= '0;
      start_sync_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cd_q         <= cd_d;
      sb_q         <= sb_d;
      sr_q         <= sr_d;
      bw_q         <= bw_d;
      rw_q         <= rw_d;
      rr_q         <= rr_d;
      frame_sync_q <= frame_sync_d;
      start_sync_q <= start_sync_d;
    end
  end

  assign bus.Game_State  = state_q;
  assign bus.reset_round = rr_q;
  assign bus.countdown   = cd_q;
  assign bus.score_blue  = sb_q;
  assign bus.score_red   = sr_q;
  assign bus.Blue_W      = bw_q;
  assign bus.Red_W       = rw_q;
endmodule

// File: tb/tb_tron_round_ctrl.sv
// Scoreboard bench for tron_round_ctrl: a round-level model queues every expected
// change of the visible outputs; a negedge monitor pops and compares each change.
`timescale 1ns/1ps
module tb_tron_round_ctrl;
  localparam int WIN = 3;
  localparam int CF  = 60;
  localparam int HF  = 90;
  localparam int ST_TITLE = 0, ST_CD = 1, ST_PLAY = 2, ST_RE = 3, ST_ME = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tron_round_if bus();

  tron_round_ctrl #(.WIN_SCORE(WIN), .COUNT_FRAMES(CF), .HOLD_FRAMES(HF)) dut (
    .Clk(clk), .Reset_N(rst_n), .bus(bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cd;
    logic [1:0] sb;
    logic [1:0] sr;
    logic       bw;
    logic       rw;
    logic       rr;
  } snap_t;

  snap_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // round-level reference model
  int    m_st = ST_TITLE, m_ticks = 0, m_sb = 0, m_sr = 0;
  bit    m_bw = 0, m_rw = 0, m_rr = 0, m_pause = 0;
  snap_t m_last;

  function automatic snap_t m_snap();
    snap_t s;
    s.st = 3'(m_st);
    s.cd = (m_st == ST_CD) ? 2'(3 - m_ticks / CF) : 2'd0;
    s.sb = 2'(m_sb);
    s.sr = 2'(m_sr);
    s.bw = m_bw;
    s.rw = m_rw;
    s.rr = m_rr;
    return s;
  endfunction

  function automatic void m_emit();
    snap_t s = m_snap();
    if (s != m_last) begin
      exp_q.push_back(s);
      m_last = s;
    end
  endfunction

  function automatic void m_enter_cd();
    m_st = ST_CD; m_ticks = 0;
    m_rr = 1; m_emit();
    m_rr = 0; m_emit();
  endfunction

  function automatic void m_reset();
    m_st = ST_TITLE; m_ticks = 0; m_sb = 0; m_sr = 0;
    m_bw = 0; m_rw = 0; m_rr = 0;
    m_emit();
  endfunction

  function automatic void m_start();
    if (m_st == ST_TITLE) m_enter_cd();
    else if (m_st == ST_ME) begin
      m_st = ST_TITLE; m_sb = 0; m_sr = 0; m_bw = 0; m_rw = 0;
      m_emit();
    end
  endfunction

  function automatic void m_tick();
    if ((m_st == ST_CD || m_st == ST_PLAY) && m_pause) return;
    if (m_st == ST_CD) begin
      m_ticks++;
      if (m_ticks == 3 * CF) m_st = ST_PLAY;
      m_emit();
    end else if (m_st == ST_RE) begin
      m_ticks++;
      if (m_ticks == HF) begin
        if (m_sb == WIN || m_sr == WIN) begin
          m_st = ST_ME; m_bw = (m_sb == WIN); m_rw = (m_sr == WIN);
          m_emit();
        end else m_enter_cd();
      end
    end
  endfunction

  function automatic void m_crash(bit b, bit r);
    if (m_st != ST_PLAY || m_pause || !(b || r)) return;
    if (b && !r && m_sr < WIN) m_sr++;
    if (r && !b && m_sb < WIN) m_sb++;
    m_st = ST_RE; m_ticks = 0;
    m_emit();
  endfunction

  // monitor: every change of the visible outputs must match the next queued snapshot
  snap_t last_seen, mon_cur, mon_exp;
  bit    mon_en  = 0;
  logic  rr_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur.st = bus.Game_State;
      mon_cur.cd = bus.countdown;
      mon_cur.sb = bus.score_blue;
      mon_cur.sr = bus.score_red;
      mon_cur.bw = bus.Blue_W;
      mon_cur.rw = bus.Red_W;
      mon_cur.rr = bus.reset_round;
      if (rr_prev) begin
        checks++;
        if (mon_cur.rr !== 1'b0) begin
          failures++;
          $display("FAIL reset_round_width got=%b expected=0 at t=%0t", mon_cur.rr, $time);
        end
      end
      rr_prev = mon_cur.rr;
      if (mon_cur !== last_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got st=%0d cd=%0d sb=%0d sr=%0d bw=%b rw=%b rr=%b expected no change at t=%0t",
                   mon_cur.st, mon_cur.cd, mon_cur.sb, mon_cur.sr, mon_cur.bw, mon_cur.rw, mon_cur.rr, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_cur !== mon_exp) begin
            failures++;
            $display("FAIL snapshot got st=%0d cd=%0d sb=%0d sr=%0d bw=%b rw=%b rr=%b expected st=%0d cd=%0d sb=%0d sr=%0d bw=%b rw=%b rr=%b at t=%0t",
                     mon_cur.st, mon_cur.cd, mon_cur.sb, mon_cur.sr, mon_cur.bw, mon_cur.rw, mon_cur.rr,
                     mon_exp.st, mon_exp.cd, mon_exp.sb, mon_exp.sr, mon_exp.bw, mon_exp.rw, mon_exp.rr, $time);
          end
        end
        last_seen = mon_cur;
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_state", int'(bus.Game_State), 0);
    chk("rst_score_blue", int'(bus.score_blue), 0);
    chk("rst_score_red", int'(bus.score_red), 0);
    chk("rst_countdown", int'(bus.countdown), 0);
    chk("rst_blue_w", int'(bus.Blue_W), 0);
    chk("rst_red_w", int'(bus.Red_W), 0);
    chk("rst_reset_round", int'(bus.reset_round), 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    m_tick();
    bus.frame_clk = 1'b1; cyc(2);
    bus.frame_clk = 1'b0; cyc(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_start();
    m_start();
    bus.start = 1'b1; cyc(2);
    bus.start = 1'b0; cyc(3);
  endtask

  task automatic crash(input bit b, input bit r);
    m_crash(b, r);
    bus.blue_crash = b; bus.red_crash = r; cyc(1);
    bus.blue_crash = 1'b0; bus.red_crash = 1'b0; cyc(2);
  endtask

  // one round from countdown entry, with ignored noise in countdown and round end
  task automatic round(input bit b, input bit r);
    int k;
    k = int'($urandom_range(0, 2));
    if (k == 1) crash(1'b1, 1'b0);
    if (k == 2) crash(1'b0, 1'b1);
    ticks(3 * CF);
    crash(b, r);
    ticks(HF / 2);
    if ($urandom_range(0, 1) == 1) press_start();
    if ($urandom_range(0, 1) == 1) crash(1'b1, 1'b1);
    ticks(HF - HF / 2);
  endtask

  task automatic random_match();
    int k, n;
    bit b, r;
    press_start();
    n = 0;
    while (m_st != ST_ME && n < 12) begin
      k = int'($urandom_range(0, 7));
      b = (k < 3) || (k >= 6);
      r = (k >= 3);
      round(b, r);
      n++;
    end
    chk("random_match_reached_end", m_st, ST_ME);
    press_start();
  endtask

  initial begin
    #10ms;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_clk  = 1'b0;
    bus.start      = 1'b0;
    bus.blue_crash = 1'b0;
    bus.red_crash  = 1'b0;
`ifdef TRON_PAUSE_EN
    bus.pause      = 1'b0;
`endif
    m_last = m_snap();
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk_reset_outputs();
    last_seen = m_last;
    mon_en = 1;

    // two blue points, then reset in the middle of the third PLAY
    press_start();
    round(1'b0, 1'b1);
    round(1'b0, 1'b1);
    ticks(3 * CF);
    chk("pre_reset_score_blue", int'(bus.score_blue), 2);
    m_reset();
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; cyc(2);
    chk_reset_outputs();

    // draw with both crash lines held through part of ROUND_END
    press_start();
    ticks(3 * CF);
    m_crash(1'b1, 1'b1);
    bus.blue_crash = 1'b1; bus.red_crash = 1'b1;
    cyc(1);
    ticks(5);
    bus.blue_crash = 1'b0; bus.red_crash = 1'b0;
    ticks(HF - 5);

    // three red wins take the match
    round(1'b1, 1'b0);
    round(1'b1, 1'b0);
    round(1'b1, 1'b0);
    chk("red_match_red_w", int'(bus.Red_W), 1);
    chk("red_match_blue_w", int'(bus.Blue_W), 0);
    press_start();

    random_match();
    random_match();

`ifdef TRON_PAUSE_EN
    press_start();
    ticks(CF + 10);
    m_pause = 1; bus.pause = 1'b1;
    ticks(200);
    chk("paused_countdown", int'(bus.countdown), 2);
    m_pause = 0; bus.pause = 1'b0;
    ticks(2 * CF - 10);
    m_pause = 1; bus.pause = 1'b1;
    crash(1'b0, 1'b1);
    m_pause = 0; bus.pause = 1'b0;
    crash(1'b0, 1'b1);
    ticks(HF);
`endif

    cyc(20);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
